hdmi_pcie_dma_sched: RTL and testbench
======================================

// Module: hdmi_pcie_dma_sched
// PURPOSE
//  Read-side scheduler for the HDMI->PCIe video FIFO (16b write / 128b read, async, no output reg).
//  Watches the FIFO read water level, requests PCIe write bursts from the DMA engine, pops the FIFO,
//  and streams 128-bit words to the TLP builder. Tracks the host frame-buffer address, wraps it per frame,
//  and flushes partial bursts at frame end.
// PARAMETERS
//  RD_DEPTH_WIDTH  12         FIFO read-side depth width; water level is RD_DEPTH_WIDTH+1 bits
//  DATA_WIDTH      128        FIFO read / TX data width
//  BURST_WORDS     16         full burst length in words (16 x 16B = 256B max payload)
//  ADDR_WIDTH      32         host byte-address width
//  FRAME_BYTES     4147200    bytes per frame (1920x1080x2); multiple of 16
// PORTS
//  clk                  in   1              clock, FIFO rd_clk domain
//  tb_rst               in   1              reset tb_rst, asynchronous, active-high
//  cfg_en               in   1              enable scheduling; sampled only in IDLE
//  cfg_base_addr        in   ADDR_WIDTH     frame-buffer base (16B aligned); sampled at each frame start
//  frame_end            in   1              1-cycle pulse: source frame complete, flush remainder
//  fifo_rd_water_level  in   RD_DEPTH_WIDTH+1  FIFO read water level (words)
//  fifo_rd_empty        in   1              FIFO empty
//  fifo_rd_en           out  1              FIFO pop; data valid on fifo_rd_data next cycle
//  fifo_rd_data         in   DATA_WIDTH     FIFO read data
//  dma_req              out  1              burst request; held until dma_ack
//  dma_addr             out  ADDR_WIDTH     burst host byte address
//  dma_len              out  5              burst length in words (1..BURST_WORDS)
//  dma_ack              in   1              DMA engine accepted request
//  tx_data              out  DATA_WIDTH     stream data
//  tx_valid             out  1              stream valid
//  tx_last              out  1              last word of burst
//  tx_ready             in   1              stream ready (valid/ready handshake)
//  frame_done           out  1              1-cycle pulse after last burst of a frame completes
//  err_underrun         out  1              sticky: fifo_rd_en asserted while fifo_rd_empty
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; addr=cfg_base_addr latched at first IDLE exit; flush_pend=0.
//  frame_end sets flush_pend (any state); cleared when frame wraps.
//  IDLE: cfg_en && wl>=BURST_WORDS -> REQ len=BURST_WORDS;
//        else cfg_en && flush_pend && wl>0 -> REQ len=wl;
//        else cfg_en && flush_pend && wl==0 -> WRAP. Full burst has priority over flush.
//  Len clamped so addr+len*16 never passes base+FRAME_BYTES.
//  REQ: dma_req=1, dma_addr/dma_len stable until dma_ack; dma_ack -> XFER (dma_req drops next cycle).
//  XFER: fifo_rd_en=1 when issued<len && (skid occupancy + in-flight) < 2; 1-cycle read latency
//        into 2-entry skid; tx_valid whenever skid non-empty; tx_last on word len-1;
//        no bubbles when tx_ready held high (1 word/cycle). All words accepted -> NEXT.
//  NEXT: addr += len*16. addr==base+FRAME_BYTES or flushed burst -> WRAP; else IDLE.
//  WRAP: frame_done=1 for one cycle; addr<=cfg_base_addr; flush_pend<=0 -> IDLE.
//  tx_valid never deasserts without handshake; tx_data stable while tx_valid && !tx_ready.
//  cfg_en deassert mid-burst: current burst completes, then stays in IDLE.
//  frame_end while wl==0 in IDLE: WRAP without a DMA request.
//  Water level counts only committed words, so rd_en never issued beyond wl sampled in IDLE;
//  any rd_en with fifo_rd_empty sets err_underrun (cleared only by reset).
//  tb_rst mid-burst: immediate return to reset values; dma_req drops asynchronously.
// STRUCTURE
//  hdmi_pcie_pkg: state enum {IDLE,REQ,XFER,NEXT,WRAP}, BYTES_PER_WORD=16, default BURST_WORDS.
//  Sub-module hdmi_pcie_skid2: 2-entry valid/ready skid buffer (DATA_WIDTH+1 incl. last).
//  Top holds FSM, issue/accept counters, address/frame counters.
// TESTING
//  1 wl=16, ack after 3 cyc, tx_ready=1 -> dma_addr=base, dma_len=16; 16 rd_en back-to-back;
//    16 tx beats, tx_last on 16th; next dma_addr=base+256.
//  2 tx_ready toggling 1/0 in burst -> no word lost/duplicated; tx_data matches FIFO order;
//    <=2 words outstanding.
//  3 wl=5 then frame_end pulse -> one burst dma_len=5, then frame_done pulse;
//    next dma_addr=cfg_base_addr.
//  4 FRAME_BYTES=512, 2 full bursts -> addrs base, base+256;
//    frame_done after 2nd; 3rd burst at base.
//  5 assert tb_rst during XFER word 7 -> all outputs 0 immediately;
//    after release first request at new cfg_base_addr.
//  6 cfg_en=0 with wl=4095 -> no dma_req; frame_end + wl=0 -> WRAP pulse only when cfg_en=1;
//    err_underrun stays 0.

Source files
------------

// File: rtl/hdmi_pcie_pkg.sv
// hdmi_pcie_pkg: shared types and constants for the HDMI->PCIe read-side DMA scheduler.
package hdmi_pcie_pkg;
    typedef enum logic [2:0] {IDLE, REQ, XFER, NEXT, WRAP} state_e;
    localparam int BYTES_PER_WORD  = 16;
    localparam int WORD_SHIFT      = 4;
    localparam int BURST_WORDS_DEF = 16;
endpackage

// File: rtl/hdmi_pcie_skid2.sv
// hdmi_pcie_skid2: 2-entry valid/ready buffer; the producer guarantees it never pushes into a full buffer.
module hdmi_pcie_skid2 #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         tb_rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    assign pop         = out_ready_i && cnt_q != 2'd0;
    assign out_valid_o = cnt_q != 2'd0;
    assign out_data_o  = mem0_q;
    assign count_o     = cnt_q;

    always_comb begin
        mem0_d = pop ? ((cnt_q == 2'd2 || !in_valid_i) ? mem1_q : in_data_i)
                     : ((in_valid_i && cnt_q == 2'd0) ? in_data_i : mem0_q);
        mem1_d = (in_valid_i && cnt_q == (pop ? 2'd2 : 2'd1)) ? in_data_i : mem1_q;
        cnt_d  = cnt_q + {1'b0, in_valid_i} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/hdmi_pcie_dma_sched.sv
// hdmi_pcie_dma_sched: pops the video FIFO in DMA-sized bursts, streams words to the TLP builder
// and walks the host frame-buffer address, wrapping per frame and flushing partial bursts at frame end.
module hdmi_pcie_dma_sched
    import hdmi_pcie_pkg::*;
#(
    parameter int RD_DEPTH_WIDTH = 12,
    parameter int DATA_WIDTH     = 128,
    parameter int BURST_WORDS    = BURST_WORDS_DEF,
    parameter int ADDR_WIDTH     = 32,
    parameter int FRAME_BYTES    = 4147200
) (
    input  logic                      clk,
    input  logic                      tb_rst,
    input  logic                      cfg_en,
    input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
    input  logic                      frame_end,
    input  logic [RD_DEPTH_WIDTH:0]   fifo_rd_water_level,
    input  logic                      fifo_rd_empty,
    output logic                      fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
    output logic                      dma_req,
    output logic [ADDR_WIDTH-1:0]     dma_addr,
    output logic [4:0]                dma_len,
    input  logic                      dma_ack,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    output logic                      tx_last,
    input  logic                      tx_ready,
    output logic                      frame_done,
    output logic                      err_underrun
);
    localparam int WL_W = RD_DEPTH_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] FRAME_B = ADDR_WIDTH'(FRAME_BYTES);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, base_q, a_eff, b_eff, rem_w, want_w, next_addr;
    logic [4:0]            len_q, issued_q, accepted_q;
    logic                  flush_pend_q, flushed_q, frame_start_q, inflight_q, last_pend_q;
    logic                  dma_req_q, frame_done_q, err_q, full, pop;
    logic [1:0]            skid_cnt;
    logic [DATA_WIDTH:0]   skid_out;

    assign dma_req      = dma_req_q;
    assign dma_addr     = addr_q;
    assign dma_len      = len_q;
    assign frame_done   = frame_done_q;
    assign err_underrun = err_q;
    assign tx_data      = skid_out[DATA_WIDTH-1:0];
    assign tx_last      = skid_out[DATA_WIDTH];

    // At frame start the base is taken live from cfg_base_addr rather than from the stale registers.
    always_comb begin
        a_eff      = frame_start_q ? cfg_base_addr : addr_q;
        b_eff      = frame_start_q ? cfg_base_addr : base_q;
        rem_w      = (b_eff + FRAME_B - a_eff) >> WORD_SHIFT;
        full       = fifo_rd_water_level >= WL_W'(BURST_WORDS);
        want_w     = full ? ADDR_WIDTH'(BURST_WORDS) : ADDR_WIDTH'(fifo_rd_water_level);
        next_addr  = addr_q + (ADDR_WIDTH'(len_q) << WORD_SHIFT);
        pop        = tx_valid && tx_ready;
        // Room check counts the word leaving the skid this cycle so a held-high tx_ready sees no bubbles.
        fifo_rd_en = state_q == XFER && issued_q < len_q
                     && (skid_cnt - {1'b0, pop} + {1'b0, inflight_q}) < 2'd2;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            base_q        <= '0;
            len_q         <= 5'd0;
            issued_q      <= 5'd0;
            accepted_q    <= 5'd0;
            flush_pend_q  <= 1'b0;
            flushed_q     <= 1'b0;
            frame_start_q <= 1'b1;
            inflight_q    <= 1'b0;
            last_pend_q   <= 1'b0;
            dma_req_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            inflight_q   <= fifo_rd_en;
            last_pend_q  <= fifo_rd_en && issued_q == len_q - 5'd1;
            err_q        <= err_q | (fifo_rd_en & fifo_rd_empty);
            case (state_q)
                IDLE: begin
                    if (cfg_en && (full || (flush_pend_q && fifo_rd_water_level != '0))) begin
                        state_q       <= REQ;
                        dma_req_q     <= 1'b1;
                        addr_q        <= a_eff;
                        base_q        <= b_eff;
                        frame_start_q <= 1'b0;
                        len_q         <= want_w < rem_w ? want_w[4:0] : rem_w[4:0];
                        flushed_q     <= !full;
                        issued_q      <= 5'd0;
                        accepted_q    <= 5'd0;
                    end else if (cfg_en && flush_pend_q) begin
                        state_q      <= WRAP;
                        frame_done_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (dma_ack) begin
                        state_q   <= XFER;
                        dma_req_q <= 1'b0;
                    end
                end
                XFER: begin
                    issued_q   <= issued_q + {4'b0, fifo_rd_en};
                    accepted_q <= accepted_q + {4'b0, pop};
                    if (accepted_q == len_q) state_q <= NEXT;
                end
                NEXT: begin
                    addr_q <= next_addr;
                    if (next_addr == base_q + FRAME_B || flushed_q) begin
                        state_q      <= WRAP;
                        frame_done_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WRAP: begin
                    state_q       <= IDLE;
                    addr_q        <= cfg_base_addr;
                    base_q        <= cfg_base_addr;
                    frame_start_q <= 1'b1;
                    flush_pend_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (frame_end) flush_pend_q <= 1'b1;
        end
    end

    hdmi_pcie_skid2 #(.W(DATA_WIDTH + 1)) u_skid (
        .clk         (clk),
        .tb_rst      (tb_rst),
        .in_valid_i  (inflight_q),
        .in_data_i   ({last_pend_q, fifo_rd_data}),
        .out_valid_o (tx_valid),
        .out_data_o  (skid_out),
        .out_ready_i (tx_ready),
        .count_o     (skid_cnt)
    );
endmodule

// File: tb/tb_hdmi_pcie_dma_sched.sv
// tb_hdmi_pcie_dma_sched: directed bench with a behavioural FIFO and DMA responder; 512-byte frames
// so that frame wrap is reached after two full bursts.
module tb_hdmi_pcie_dma_sched;
    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int WLW = 13;

    logic          clk = 1'b0, tb_rst = 1'b1, cfg_en = 1'b0, frame_end = 1'b0;
    logic          dma_ack = 1'b0, tx_ready = 1'b1;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty, fifo_rd_en, dma_req, tx_valid, tx_last, frame_done, err_underrun;
    logic [WLW-1:0] fifo_rd_water_level;
    logic [AW-1:0] dma_addr;
    logic [4:0]    dma_len;
    logic [DW-1:0] tx_data;

    int avail = 0, popped = 0, rd_cnt = 0, out_max = 0, fd_cycles = 0, stall_viol = 0;
    int checks = 0, errors = 0, skip = 0;
    logic [DW-1:0] txq[$];
    logic          lastq[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    hdmi_pcie_dma_sched #(.FRAME_BYTES(512)) dut (
        .clk                 (clk),
        .tb_rst              (tb_rst),
        .cfg_en              (cfg_en),
        .cfg_base_addr       (cfg_base_addr),
        .frame_end           (frame_end),
        .fifo_rd_water_level (fifo_rd_water_level),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .dma_req             (dma_req),
        .dma_addr            (dma_addr),
        .dma_len             (dma_len),
        .dma_ack             (dma_ack),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_last             (tx_last),
        .tx_ready            (tx_ready),
        .frame_done          (frame_done),
        .err_underrun        (err_underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] tag(input int i);
        return DW'(32'hC0DE_0000 + 32'(i));
    endfunction

    assign fifo_rd_water_level = WLW'(avail - popped);
    assign fifo_rd_empty       = avail == popped;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= tag(popped);
            popped       <= popped + 1;
        end
    end

    // Stream monitor: logs handshakes, outstanding words, stall stability and frame_done width.
    always @(negedge clk) begin
        if (!tb_rst) begin
            if (tx_valid && tx_ready) begin
                txq.push_back(tx_data);
                lastq.push_back(tx_last);
            end
            if (fifo_rd_en) rd_cnt++;
            if (rd_cnt - txq.size() > out_max) out_max = rd_cnt - txq.size();
            if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_viol++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (frame_done) fd_cycles++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!dma_req && n < 100) begin
            tick();
            n++;
        end
        chk("req_seen", DW'(dma_req), DW'(1));
    endtask

    task automatic wait_fd(input int e);
        int n = 0;
        while (fd_cycles < e && n < 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("frame_done_pulse", DW'(fd_cycles), DW'(e));
    endtask

    task automatic do_burst(input logic [AW-1:0] ea, input int el, input int ack_dly, input bit toggle);
        int b0, n, rd_n, rd_first, rd_last;
        wait_req();
        chk("dma_addr", DW'(dma_addr), DW'(ea));
        chk("dma_len", DW'(dma_len), DW'(el));
        repeat (ack_dly) tick();
        chk("req_held", DW'({dma_req, dma_addr, dma_len}), DW'({1'b1, ea, 5'(el)}));
        b0 = txq.size();
        dma_ack = 1'b1;
        tick();
        dma_ack = 1'b0;
        chk("req_drop", DW'(dma_req), DW'(0));
        rd_n = 0; rd_first = -1; rd_last = -1; n = 0;
        while (txq.size() < b0 + el && n < 300) begin
            tx_ready = toggle ? (n % 2 == 0) : 1'b1;
            @(negedge clk);
            if (fifo_rd_en) begin
                rd_n++;
                if (rd_first < 0) rd_first = n;
                rd_last = n;
            end
            tick();
            n++;
        end
        tx_ready = 1'b1;
        chk("burst_words", DW'(txq.size() - b0), DW'(el));
        chk("rd_count", DW'(rd_n), DW'(el));
        if (!toggle) chk("rd_back2back", DW'(rd_last - rd_first + 1), DW'(el));
        for (int i = 0; i < el && b0 + i < txq.size(); i++) begin
            chk("tx_data", txq[b0+i], tag(b0 + i + skip));
            chk("tx_last", DW'(lastq[b0+i]), DW'(i == el - 1));
        end
    endtask

    initial begin
        int b0, n, n_req;
        cfg_base_addr = 32'h1000_0000;
        repeat (3) tick();
        chk("rst_flags", DW'({dma_req, fifo_rd_en, tx_valid, tx_last, frame_done, err_underrun}), DW'(0));
        chk("rst_addr", DW'(dma_addr), DW'(0));
        chk("rst_len", DW'(dma_len), DW'(0));
        chk("rst_data", tx_data, DW'(0));
        avail = 16;
        cfg_en = 1'b1;
        tb_rst = 1'b0;
        // full burst, ack after 3 cycles
        do_burst(32'h1000_0000, 16, 3, 1'b0);
        // second burst with tx_ready toggling; reaches end of the 512-byte frame
        avail += 16;
        do_burst(32'h1000_0100, 16, 1, 1'b1);
        chk("outstanding_le2", DW'(out_max <= 2), DW'(1));
        chk("stall_stable", DW'(stall_viol), DW'(0));
        wait_fd(1);
        avail += 16;
        do_burst(32'h1000_0000, 16, 0, 1'b0);
        chk("no_fd_midframe", DW'(fd_cycles), DW'(1));
        // partial burst flushed by frame_end
        avail += 5;
        tick();
        tick();
        chk("no_req_partial", DW'(dma_req), DW'(0));
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        do_burst(32'h1000_0100, 5, 2, 1'b0);
        wait_fd(2);
        // new frame at new base, then reset in the middle of the burst
        cfg_base_addr = 32'h2000_0000;
        avail += 16;
        wait_req();
        chk("wrap_addr", DW'(dma_addr), DW'(32'h2000_0000));
        chk("wrap_len", DW'(dma_len), DW'(16));
        b0 = txq.size();
        dma_ack = 1'b1;
        tick();
        dma_ack = 1'b0;
        n = 0;
        while (txq.size() < b0 + 7 && n < 100) begin
            tick();
            n++;
        end
        chk("pre_rst_words", DW'(txq.size() - b0), DW'(7));
        tb_rst = 1'b1;
        #1;
        chk("rst_mid_flags", DW'({dma_req, fifo_rd_en, tx_valid, tx_last, frame_done, err_underrun}), DW'(0));
        chk("rst_mid_addr", DW'(dma_addr), DW'(0));
        chk("rst_mid_len", DW'(dma_len), DW'(0));
        cfg_base_addr = 32'h3000_0000;
        tick();
        tick();
        skip = popped - txq.size();
        avail = popped + 16;
        tb_rst = 1'b0;
        do_burst(32'h3000_0000, 16, 1, 1'b0);
        // disabled scheduler ignores a full FIFO and a pending flush
        cfg_en = 1'b0;
        avail = popped + 4095;
        n_req = 0;
        repeat (30) begin
            tick();
            if (dma_req) n_req++;
        end
        chk("no_req_disabled", DW'(n_req), DW'(0));
        avail = popped;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (10) tick();
        chk("no_wrap_disabled", DW'(fd_cycles), DW'(2));
        cfg_en = 1'b1;
        wait_fd(3);
        chk("no_req_on_wrap", DW'(dma_req), DW'(0));
        chk("underrun", DW'(err_underrun), DW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
